// File: rtl/pipe_seq_ctrl_if.sv
// Pipeline-sequencer bus: hazard/redirect status in from the datapath and stage
// enables, flush/bubble and LM/SM micro-op steering back out.
interface pipe_seq_ctrl_if;
  logic       ex_valid;
  logic       ex_is_load;
  logic [2:0] ex_dest;
  logic       rf_valid;
  logic [2:0] rf_src1;
  logic [2:0] rf_src2;
  logic [1:0] rf_src_used;
  logic       rf_is_multi;
  logic [7:0] rf_reglist;
  logic       br_taken;
  logic       mem_stall;

  logic        pc_en;
  logic        if_id_en;
  logic        id_rf_en;
  logic        rf_ex_en;
  logic        front_flush;
  logic        rf_ex_bubble;
  logic [2:0]  multi_idx;
  logic        multi_last;
  logic [15:0] stall_cycles;

  modport master (
    output ex_valid, ex_is_load, ex_dest, rf_valid, rf_src1, rf_src2,
           rf_src_used, rf_is_multi, rf_reglist, br_taken, mem_stall,
    input  pc_en, if_id_en, id_rf_en, rf_ex_en, front_flush, rf_ex_bubble,
           multi_idx, multi_last, stall_cycles
  );

  modport slave (
    input  ex_valid, ex_is_load, ex_dest, rf_valid, rf_src1, rf_src2,
           rf_src_used, rf_is_multi, rf_reglist, br_taken, mem_stall,
    output pc_en, if_id_en, id_rf_en, rf_ex_en, front_flush, rf_ex_bubble,
           multi_idx, multi_last, stall_cycles
  );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: stalls, redirects, load-use bubbles and LM/SM expansion.
// Optional front-end stall counter enabled by defining PIPE_SEQ_PERF_CNT_EN.
module pipe_seq_ctrl (
  input  logic             clock,
  input  logic             reset,
  pipe_seq_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MULTI = 2'b01,
    DRAIN = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pending, pending_nxt;
  logic [2:0] lo_idx;
  logic       one_left;
  logic       load_use;
  logic       multi_go;
  logic       up_en, rf_ex_en, flush, bubble, last;
  logic [2:0] idx;

  always_comb begin
    lo_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (pending[i]) lo_idx = 3'(i);
  end

  assign one_left = (pending != 8'h00) && ((pending & (pending - 8'd1)) == 8'h00);

  assign load_use = bus.ex_valid & bus.ex_is_load & bus.rf_valid &
                    ((bus.rf_src_used[0] & (bus.rf_src1 == bus.ex_dest)) |
                     (bus.rf_src_used[1] & (bus.rf_src2 == bus.ex_dest)));

  assign multi_go = bus.rf_valid & bus.rf_is_multi & (bus.rf_reglist != 8'h00);

  always_comb begin
    up_en       = 1'b1;
    rf_ex_en    = 1'b1;
    flush       = 1'b0;
    bubble      = 1'b0;
    idx         = 3'd0;
    last        = 1'b0;
    state_nxt   = state;
    pending_nxt = pending;
    if (!reset) begin
      up_en       = 1'b0;
      rf_ex_en    = 1'b0;
      flush       = 1'b1;
      bubble      = 1'b1;
      state_nxt   = RUN;
      pending_nxt = 8'h00;
    end else if (state == BAD) begin
      state_nxt   = RUN;
      pending_nxt = 8'h00;
    end else if (bus.mem_stall) begin
      // Freeze everything; keep showing the stalled micro-op's register.
      up_en    = 1'b0;
      rf_ex_en = 1'b0;
      if (state == MULTI) idx = lo_idx;
    end else if (bus.br_taken) begin
      flush       = 1'b1;
      bubble      = 1'b1;
      state_nxt   = DRAIN;
      pending_nxt = 8'h00;
    end else begin
      case (state)
        DRAIN: begin
          flush     = 1'b1;
          bubble    = 1'b1;
          state_nxt = RUN;
        end
        MULTI: begin
          idx         = lo_idx;
          last        = one_left;
          up_en       = one_left;
          pending_nxt = pending & (pending - 8'd1);
          if (one_left || pending == 8'h00) state_nxt = RUN;
        end
        default: begin
          if (load_use) begin
            up_en  = 1'b0;
            bubble = 1'b1;
          end else if (multi_go) begin
            up_en       = 1'b0;
            bubble      = 1'b1;
            pending_nxt = bus.rf_reglist;
            state_nxt   = MULTI;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= RUN;
      pending <= 8'h00;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  assign bus.pc_en        = up_en;
  assign bus.if_id_en     = up_en;
  assign bus.id_rf_en     = up_en;
  assign bus.rf_ex_en     = rf_ex_en;
  assign bus.front_flush  = flush;
  assign bus.rf_ex_bubble = bubble;
  assign bus.multi_idx    = idx;
  assign bus.multi_last   = last;

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clock) begin
    if (!reset)
      stall_cnt <= 16'h0000;
    else if (!up_en && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: queue-based reference model checked every
// cycle, plus literal per-cycle expectations on the documented scenarios.
module tb_pipe_seq_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  pipe_seq_ctrl_if bus ();

  pipe_seq_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  localparam logic [9:0] O_DEF   = 10'b1111_00_000_0;
  localparam logic [9:0] O_RST   = 10'b0000_11_000_0;
  localparam logic [9:0] O_LU    = 10'b0001_01_000_0;
  localparam logic [9:0] O_FLUSH = 10'b1111_11_000_0;
  localparam logic [9:0] O_IDX2  = 10'b0001_00_010_0;
  localparam logic [9:0] O_IDX5  = 10'b0001_00_101_0;
  localparam logic [9:0] O_IDX7L = 10'b1111_00_111_1;
  localparam logic [9:0] O_STL5  = 10'b0000_00_101_0;
  localparam logic [9:0] O_IDX0L = 10'b1111_00_000_1;

  function automatic logic [9:0] outs();
    return {bus.pc_en, bus.if_id_en, bus.id_rf_en, bus.rf_ex_en,
            bus.front_flush, bus.rf_ex_bubble, bus.multi_idx, bus.multi_last};
  endfunction

  // Reference model: remaining LM/SM registers as an ordered queue.
  int mq[$];
  bit drain = 1'b0;
  int cnt   = 0;

  always @(negedge clock) begin
    logic [9:0] e;
    bit up, rfx, fl, bb, lst, lu;
    int ix;
    if (chk_on) begin
      up = 1; rfx = 1; fl = 0; bb = 0; ix = 0; lst = 0;
      lu = bus.ex_valid && bus.ex_is_load && bus.rf_valid &&
           ((bus.rf_src_used[0] && bus.rf_src1 == bus.ex_dest) ||
            (bus.rf_src_used[1] && bus.rf_src2 == bus.ex_dest));
      if (!reset) begin
        up = 0; rfx = 0; fl = 1; bb = 1;
      end else if (bus.mem_stall) begin
        up = 0; rfx = 0;
        if (mq.size() > 0) ix = mq[0];
      end else if (bus.br_taken || drain) begin
        fl = 1; bb = 1;
      end else if (mq.size() > 0) begin
        ix = mq[0]; lst = (mq.size() == 1); up = lst;
      end else if (lu) begin
        up = 0; bb = 1;
      end else if (bus.rf_valid && bus.rf_is_multi && bus.rf_reglist != 8'h00) begin
        up = 0; bb = 1;
      end
      e = {up, up, up, rfx, fl, bb, 3'(ix), lst};
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL model_outs t=%0t got=%b exp=%b", $time, outs(), e);
      end
      checks++;
      if (bus.stall_cycles !== 16'(cnt)) begin
        failures++;
        $display("FAIL model_stall_cycles t=%0t got=%0d exp=%0d", $time, bus.stall_cycles, cnt);
      end
      // advance model to the state after the coming edge
      if (!reset) begin
        mq.delete(); drain = 0; cnt = 0;
      end else begin
`ifdef PIPE_SEQ_PERF_CNT_EN
        if (!up && cnt < 65535) cnt++;
`endif
        if (bus.mem_stall) begin
        end else if (bus.br_taken) begin
          mq.delete(); drain = 1;
        end else if (drain) begin
          drain = 0;
        end else if (mq.size() > 0) begin
          void'(mq.pop_front());
        end else if (!lu && bus.rf_valid && bus.rf_is_multi && bus.rf_reglist != 8'h00) begin
          for (int i = 0; i < 8; i++) if (bus.rf_reglist[i]) mq.push_back(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic lit(input string nm, input logic [9:0] exp);
    #1;
    checks++;
    if (outs() !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, outs(), exp);
    end
  endtask

  task automatic idle();
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_dest = 0;
    bus.rf_valid = 0; bus.rf_src1 = 0; bus.rf_src2 = 0; bus.rf_src_used = 0;
    bus.rf_is_multi = 0; bus.rf_reglist = 0; bus.br_taken = 0; bus.mem_stall = 0;
  endtask

  task automatic lm(input logic [7:0] rl);
    bus.rf_valid = 1; bus.rf_is_multi = 1; bus.rf_reglist = rl;
  endtask

  initial begin
    idle();
    reset = 0;
    lit("reset_outs", O_RST);
    tick(); tick();
    chk_on = 1;
    lit("reset_outs_held", O_RST);
    reset = 1;
    lit("run_default", O_DEF);
    tick();

    // load-use on src1
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_dest = 3;
    bus.rf_valid = 1; bus.rf_src1 = 3; bus.rf_src_used = 2'b01;
    lit("load_use_src1", O_LU);
    tick();
    bus.ex_valid = 0;
    lit("after_load_use", O_DEF);
    // matching register but source not used / not a load
    bus.ex_valid = 1; bus.rf_src_used = 2'b10; bus.rf_src2 = 1;
    lit("no_hazard_unused_src", O_DEF);
    bus.rf_src_used = 2'b01; bus.ex_is_load = 0;
    lit("no_hazard_not_load", O_DEF);
    tick(); idle();

    // LM 1010_0100: entry + idx 2,5,7
    lm(8'b1010_0100);
    lit("lm_entry", O_LU); tick();
    lit("lm_idx2", O_IDX2); tick();
    lit("lm_idx5", O_IDX5); tick();
    lit("lm_idx7_last", O_IDX7L); tick();
    idle();
    lit("lm_done", O_DEF); tick();

    // redirect after idx 2
    lm(8'b1010_0100);
    lit("br_lm_entry", O_LU); tick();
    lit("br_lm_idx2", O_IDX2); tick();
    bus.br_taken = 1;
    lit("br_flush", O_FLUSH); tick();
    idle();
    lit("br_drain", O_FLUSH); tick();
    lit("br_run1", O_DEF); tick();
    lit("br_run2_no_idx5", O_DEF); tick();

    // memory stall for 3 cycles mid-sequence
    lm(8'b1010_0100);
    lit("stl_entry", O_LU); tick();
    lit("stl_idx2", O_IDX2); tick();
    bus.mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      lit("stl_frozen", O_STL5); tick();
    end
    bus.mem_stall = 0;
    lit("stl_resume_idx5", O_IDX5); tick();
    lit("stl_idx7_last", O_IDX7L); tick();
    idle();
    lit("stl_done", O_DEF); tick();

    // empty register list passes as a no-op
    lm(8'h00);
    lit("lm_empty", O_DEF); tick(); idle();

    // load-use outranks multi entry, then single-register LM
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_dest = 5;
    bus.rf_src2 = 5; bus.rf_src_used = 2'b10;
    lm(8'h01);
    lit("lu_over_multi", O_LU); tick();
    bus.ex_valid = 0;
    lit("single_entry", O_LU); tick();
    lit("single_idx0_last", O_IDX0L); tick();
    idle();
    lit("single_done", O_DEF); tick();

    // redirect during drain restarts drain
    bus.br_taken = 1;
    lit("br_a", O_FLUSH); tick();
    lit("br_in_drain", O_FLUSH); tick();
    bus.br_taken = 0;
    lit("drain_again", O_FLUSH); tick();
    lit("drain_exit", O_DEF); tick();

    // reset mid-sequence
    lm(8'b1010_0100);
    lit("rst_entry", O_LU); tick();
    lit("rst_idx2", O_IDX2); tick();
    reset = 0;
    lit("rst_mid_multi", O_RST); tick();
    reset = 1; idle();
    lit("rst_back_run", O_DEF); tick();
    lit("rst_no_leftover", O_DEF); tick();

`ifdef PIPE_SEQ_PERF_CNT_EN
    bus.mem_stall = 1;
    repeat (70000) tick();
    bus.mem_stall = 0;
    #1;
    checks++;
    if (bus.stall_cycles !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_cycles_saturate got=%h exp=ffff", bus.stall_cycles);
    end
    tick();
`endif

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
